repeated_sub_divider: RTL and testbench
=======================================

REPEATED_SUB_DIVIDER -- requirements
Module: repeated_sub_divider

Interface
REQ-001 Parameter: W, default 8, operand/result width in bits; all values below assume W=8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserting 0 clears all state immediately, independent of clk.
REQ-004 start  input  1  begin operation; sampled only in IDLE and DONE.
REQ-005 data_in  input  W  shared operand bus: dividend on the start cycle, divisor on the following cycle.
REQ-006 quotient  output  W  registered quotient; valid while done=1.
REQ-007 remainder  output  W  registered remainder; valid while done=1.
REQ-008 busy  output  1  high in LDB and CALC states.
REQ-009 done  output  1  high in DONE state (level, not pulse).
REQ-010 div_zero  output  1  divide-by-zero flag; valid while done=1.

Function
REQ-011 States SHALL be IDLE, LDB, CALC and DONE, encoded in a registered state machine with a separate datapath (operand regs A, B, Q, R).
REQ-012 IDLE or DONE with start=1: A<=data_in, state->LDB; start=0: state unchanged.
REQ-013 LDB: B<=data_in, R<=A, Q<=0, div_zero<=0, state->CALC; start ignored.
REQ-014 CALC, per edge: if R>=B and Q!=2^W-1: R<=R-B, Q<=Q+1, stay in CALC; otherwise state->DONE; start ignored.
REQ-015 Subtraction is unsigned W-bit; R never underflows because it is guarded by R>=B.
REQ-016 Latency: done SHALL rise (q+2) rising edges after the edge that sampled start, where q is the final quotient.
REQ-017 quotient and remainder SHALL hold stable in DONE until the LDB of the next operation.
REQ-018 Dividend 0 with nonzero divisor: quotient=0, remainder=0, done after 2 edges.
REQ-019 Dividend < divisor: quotient=0, remainder=dividend.
REQ-020 start asserted while busy=1 SHALL have no effect; data_in changes while busy=1 SHALL have no effect.
REQ-021 A start in DONE SHALL drop done on the next edge and begin a new operation (back-to-back supported).

Reset
REQ-022 While reset=0: state=IDLE, A=B=Q=R=0, quotient=0, remainder=0, busy=0, done=0, div_zero=0.
REQ-023 Reset asserted mid-operation SHALL abort the operation without producing done; the first edge after release SHALL behave as in IDLE.

Configuration
REQ-024 Macro DIV_ZERO_DETECT_EN controls divide-by-zero detection.
REQ-025 With DIV_ZERO_DETECT_EN defined: in CALC with B=0, state->DONE on the first CALC edge with div_zero<=1, quotient=2^W-1 and remainder=dividend; done rises 2 edges after start.
REQ-026 Without DIV_ZERO_DETECT_EN: div_zero is tied 0; B=0 subtracts 0 until Q saturates at 2^W-1 per REQ-014, giving quotient=255, remainder=dividend, and done after 257 edges.

Verification
REQ-027 Stimulus start with data_in=100, then 7 -> done after 16 edges with quotient=14, remainder=2, div_zero=0.
REQ-028 Stimulus 255 / 1 -> quotient=255, remainder=0, done after 257 edges; also 5 / 9 -> quotient=0, remainder=5, done after 2 edges.
REQ-029 Stimulus 42 / 0 -> with macro: done after 2 edges, div_zero=1, quotient=255, remainder=42; without macro: done after 257 edges, div_zero=0, same results.
REQ-030 Stimulus 200 / 3 with reset pulsed low at edge 10 -> all outputs 0 immediately and done never asserts; a following 9 / 3 yields quotient=3, remainder=0.
REQ-031 Stimulus 50 / 5, toggle start and data_in throughout CALC, then start in DONE with 17 / 4 -> first result quotient=10, remainder=0 unaffected; done drops on next edge; second result quotient=4, remainder=1.

Source files
------------

// File: rtl/repeated_sub_divider.sv
// Purpose : unsigned W-bit divider by repeated subtraction (IDLE/LDB/CALC/DONE FSM plus A/B/Q/R datapath).
// Latency : done rises q+2 clock edges after the edge that samples start (q = final quotient).
// Backpres: start is ignored while busy; a start while done is high begins the next operation.
// Optional: define DIV_ZERO_DETECT_EN to finish immediately with div_zero=1 on a zero divisor.
module repeated_sub_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LDB  = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [W-1:0] QMAX = '1;

  state_t       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] r_q, r_d;
`ifdef DIV_ZERO_DETECT_EN
  logic         dz_q, dz_d;
`endif

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  // Divide-by-zero flag register, only present when detection is built in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= dz_d;
    end
  end
`endif

  // Next-state and datapath update; everything holds unless a state says otherwise.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    r_d     = r_q;
`ifdef DIV_ZERO_DETECT_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Dividend arrives with start; quotient/remainder keep the old result until LDB.
        if (start) begin
          a_d     = data_in;
          state_d = S_LDB;
        end
      end
      S_LDB: begin
        // Divisor arrives one cycle after start; seed the working registers.
        b_d     = data_in;
        r_d     = a_q;
        q_d     = '0;
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = 1'b0;
`endif
        state_d = S_CALC;
      end
      S_CALC: begin
`ifdef DIV_ZERO_DETECT_EN
        if (b_q == '0) begin
          // Zero divisor: saturate the quotient and leave the dividend as remainder.
          dz_d    = 1'b1;
          q_d     = QMAX;
          state_d = S_DONE;
        end else if (r_q >= b_q && q_q != QMAX) begin
          r_d = r_q - b_q;
          q_d = q_q + 1'b1;
        end else begin
          state_d = S_DONE;
        end
`else
        // The QMAX guard also bounds the zero-divisor case, which otherwise never ends.
        if (r_q >= b_q && q_q != QMAX) begin
          r_d = r_q - b_q;
          q_d = q_q + 1'b1;
        end else begin
          state_d = S_DONE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign quotient  = q_q;
  assign remainder = r_q;
  assign busy      = (state_q == S_LDB) || (state_q == S_CALC);
  assign done      = (state_q == S_DONE);
`ifdef DIV_ZERO_DETECT_EN
  assign div_zero  = dz_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Purpose : self-checking bench for repeated_sub_divider; scoreboard of expected results vs DUT.
// Latency : each result is also checked for the q+2 edge start-to-done latency.
// Backpres: start/data_in are toggled while busy and must be ignored by the DUT.
module tb_repeated_sub_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;

  repeated_sub_divider #(.W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .data_in   (data_in),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  // Count rising edges so latency can be measured as an edge difference.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int q;
    int r;
    int dz;
    int start_edge;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic done_prev = 1'b0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: plain integer division, with the zero-divisor rules layered on top.
  function automatic exp_t model(int a, int b, int start_edge);
    exp_t e;
    e.start_edge = start_edge;
    e.dz = 0;
    if (b == 0) begin
      e.q = 255;
      e.r = a;
`ifdef DIV_ZERO_DETECT_EN
      e.dz  = 1;
      e.lat = 2;
`else
      e.lat = 257;
`endif
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.lat = (a / b) + 2;
    end
    return e;
  endfunction

  // Monitor: on every rising of done, pop the oldest expectation and compare.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no result pending (time %0t)", $time);
      end else begin
        e = sb.pop_front();
        check("quotient", int'(quotient), e.q);
        check("remainder", int'(remainder), e.r);
        check("div_zero", int'(div_zero), e.dz);
        check("latency", cyc - e.start_edge, e.lat);
      end
    end
    done_prev = done;
  end

  // Issue one operation starting at a negedge; returns at a negedge with done high.
  task automatic run_op(input int a, input int b, input bit noisy, input bit hold);
    exp_t e;
    bit   seen;
    e = model(a, b, cyc + 1);
    sb.push_back(e);
    start   = 1'b1;
    data_in = 8'(a);
    @(negedge clk);
    start   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    data_in = 8'(b);
    check("ldb_busy", int'(busy), 1);
    check("ldb_done_low", int'(done), 0);
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen    = 1'b1;
        start   = 1'b0;
        data_in = 8'($urandom);
      end else begin
        start   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        data_in = 8'($urandom);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 400 cycles, expected done for %0d/%0d", a, b);
      if (sb.size() != 0) void'(sb.pop_back());
    end else if (hold) begin
      repeat (3) begin
        @(negedge clk);
        data_in = 8'($urandom);
      end
      check("hold_done", int'(done), 1);
      check("hold_quotient", int'(quotient), e.q);
      check("hold_remainder", int'(remainder), e.r);
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int a;
    int b;
    // Reset state.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_div_zero", int'(div_zero), 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", int'(busy), 0);

    // Directed cases.
    run_op(100, 7, 1'b0, 1'b1);
    run_op(255, 1, 1'b0, 1'b0);
    run_op(5, 9, 1'b0, 1'b1);
    run_op(42, 0, 1'b0, 1'b1);
    run_op(0, 13, 1'b0, 1'b0);

    // Reset in the middle of 200/3: outputs clear at once and no result appears.
    start   = 1'b1;
    data_in = 8'd200;
    @(negedge clk);
    start   = 1'b0;
    data_in = 8'd3;
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_div_zero", int'(div_zero), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_done", int'(done), 0);
    run_op(9, 3, 1'b0, 1'b0);

    // Noisy inputs during CALC, then back-to-back start straight from DONE.
    run_op(50, 5, 1'b1, 1'b0);
    run_op(17, 4, 1'b0, 1'b1);

    // Randomized operations, occasionally with a zero divisor.
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) begin
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
      end
      run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
